// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one single-ported sync SRAM between the fetch and data ports.
// Data wins collisions until fetch has waited STARVE_MAX consecutive data grants.
module rv32i_mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i_req_i,
    input  logic [31:0]       i_addr_i,
    output logic              i_ready_o,
    output logic              i_rvalid_o,
    output logic [31:0]       i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_wstrb_i,
    input  logic [31:0]       d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_ready_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              m_en_o,
    output logic [3:0]        m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [31:0]       m_wdata_o,
    input  logic [31:0]       m_rdata_i
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic [3:0] starve_q, starve_d;
    logic       resp_v_q, resp_v_d;
    logic       resp_sel_q, resp_sel_d;
    logic       resp_wr_q, resp_wr_d;
    logic       grant_i, grant_d;
    logic       unused_addr_bits;
    assign unused_addr_bits = ^{i_addr_i[31:ADDR_W+2], i_addr_i[1:0], d_addr_i[31:ADDR_W+2], d_addr_i[1:0]};
    always_comb begin
        grant_d    = rst_ni && d_req_i && !(i_req_i && starve_q == SMAX);
        grant_i    = rst_ni && i_req_i && !grant_d;
        starve_d   = (i_req_i && grant_d) ? ((starve_q == SMAX) ? SMAX : starve_q + 4'd1) : 4'd0;
        resp_v_d   = grant_i || grant_d;
        resp_sel_d = grant_d;
        resp_wr_d  = grant_d && d_we_i;
    end
    assign i_ready_o = grant_i;
    assign d_ready_o = grant_d;
    assign m_en_o    = grant_i || grant_d;
    assign m_addr_o  = grant_d ? d_addr_i[ADDR_W+1:2] : (grant_i ? i_addr_i[ADDR_W+1:2] : '0);
    assign m_we_o    = (grant_d && d_we_i) ? d_wstrb_i : 4'd0;
    assign m_wdata_o = grant_d ? d_wdata_i : 32'd0;
    // rvalid is gated by rst_ni so a response due while reset is asserted is dropped
    assign i_rvalid_o = rst_ni && resp_v_q && !resp_sel_q;
    assign d_rvalid_o = rst_ni && resp_v_q && resp_sel_q;
    assign i_rdata_o  = i_rvalid_o ? m_rdata_i : 32'd0;
    assign d_rdata_o  = (d_rvalid_o && !resp_wr_q) ? m_rdata_i : 32'd0;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            starve_q   <= 4'd0;
            resp_v_q   <= 1'b0;
            resp_sel_q <= 1'b0;
            resp_wr_q  <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            resp_v_q   <= resp_v_d;
            resp_sel_q <= resp_sel_d;
            resp_wr_q  <= resp_wr_d;
        end
    end
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter: directed and random checks of the arbiter against a request-level model.
module tb_rv32i_mem_arbiter;
    localparam int AW = 12;
    localparam int SM = 4;
    localparam int DEPTH = 1 << AW;
    typedef struct {
        bit          sel;
        logic [31:0] data;
    } resp_t;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0]   i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]    d_wstrb = '0;
    logic          i_ready, i_rvalid, d_ready, d_rvalid, m_en;
    logic [31:0]   i_rdata, d_rdata, m_wdata, m_rdata;
    logic [3:0]    m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   ref_mem [DEPTH];
    resp_t         q[$];
    int            waits = 0;
    int            total = 0;
    int            bad = 0;
    logic          last_ir, last_dr, last_irv, last_drv;
    logic [31:0]   last_irdata, last_drdata, last_maddr;
    always #5 clk = ~clk;
    rv32i_mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_ready_o(i_ready), .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_wstrb_i(d_wstrb), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_ready_o(d_ready), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .m_en_o(m_en), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata), .m_rdata_i(m_rdata)
    );
    // Registered-read SRAM driven by the arbiter
    always @(posedge clk) begin
        if (m_en) begin
            m_rdata <= mem[m_addr];
            for (int b = 0; b < 4; b++)
                if (m_we[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        int          g;
        logic [31:0] ea;
        resp_t       r;
        bit          rv;
        @(negedge clk);
        g = 0;
        if (rst_n) begin
            if (d_req && !(i_req && waits == SM)) g = 2;
            else if (i_req) g = 1;
        end
        ea = (g == 2) ? (d_addr >> 2) % DEPTH : (g == 1) ? (i_addr >> 2) % DEPTH : 32'd0;
        chk("i_ready", 32'(i_ready), 32'(g == 1));
        chk("d_ready", 32'(d_ready), 32'(g == 2));
        chk("m_en", 32'(m_en), 32'(g != 0));
        chk("m_addr", 32'(m_addr), ea);
        chk("m_we", 32'(m_we), (g == 2 && d_we) ? 32'(d_wstrb) : 32'd0);
        chk("m_wdata", m_wdata, (g == 2) ? d_wdata : 32'd0);
        rv = rst_n && q.size() > 0;
        r.sel = 1'b0;
        r.data = '0;
        if (rv) r = q[0];
        chk("i_rvalid", 32'(i_rvalid), 32'(rv && !r.sel));
        chk("d_rvalid", 32'(d_rvalid), 32'(rv && r.sel));
        chk("i_rdata", i_rdata, (rv && !r.sel) ? r.data : 32'd0);
        chk("d_rdata", d_rdata, (rv && r.sel) ? r.data : 32'd0);
        last_ir = i_ready; last_dr = d_ready; last_irv = i_rvalid; last_drv = d_rvalid;
        last_irdata = i_rdata; last_drdata = d_rdata; last_maddr = 32'(m_addr);
        @(posedge clk);
        if (q.size() > 0) void'(q.pop_front());
        if (!rst_n) begin
            q.delete();
            waits = 0;
        end else begin
            if (g != 0) begin
                r.sel = (g == 2);
                r.data = (g == 2 && d_we) ? 32'd0 : ref_mem[ea[AW-1:0]];
                q.push_back(r);
                if (g == 2 && d_we)
                    for (int b = 0; b < 4; b++)
                        if (d_wstrb[b]) ref_mem[ea[AW-1:0]][8*b +: 8] = d_wdata[8*b +: 8];
            end
            waits = (g == 2 && i_req) ? ((waits < SM) ? waits + 1 : SM) : 0;
        end
        #1;
    endtask
    initial begin
        logic [9:0] pat;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = $urandom;
        ref_mem[3] = 32'h0000_0013;
        ref_mem[16] = 32'h1122_3344;
        for (int k = 0; k < DEPTH; k++) mem[k] <= ref_mem[k];
        #1;
        i_req = 1'b1; d_req = 1'b1;
        cyc(); cyc();
        chk("reset_no_grant", 32'({last_ir, last_dr}), 32'd0);
        rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0;
        cyc();
        i_req = 1'b1; i_addr = 32'h0000_000C;
        cyc();
        chk("fetch_grant", 32'(last_ir), 32'd1);
        chk("fetch_maddr", last_maddr, 32'd3);
        i_req = 1'b0;
        cyc();
        chk("fetch_rvalid", 32'(last_irv), 32'd1);
        chk("fetch_rdata", last_irdata, 32'h0000_0013);
        chk("fetch_no_drvalid", 32'(last_drv), 32'd0);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h41; d_wstrb = 4'b0010; d_wdata = 32'h0000_AB00;
        cyc();
        d_we = 1'b0; d_addr = 32'h40;
        cyc();
        chk("wr_ack", 32'(last_drv), 32'd1);
        chk("wr_rdata", last_drdata, 32'd0);
        d_req = 1'b0;
        cyc();
        chk("rd_after_wr", last_drdata, 32'h1122_AB44);
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h10; d_addr = 32'h20;
        cyc();
        chk("col_d_ready", 32'(last_dr), 32'd1);
        chk("col_i_ready", 32'(last_ir), 32'd0);
        d_req = 1'b0;
        cyc();
        chk("col_d_rvalid", 32'(last_drv), 32'd1);
        chk("col_i_rvalid", 32'(last_irv), 32'd0);
        chk("col_i_next", 32'(last_ir), 32'd1);
        i_req = 1'b0;
        cyc();
        i_req = 1'b1; d_req = 1'b1; pat = '0;
        for (int n = 0; n < 10; n++) begin
            cyc();
            pat = {pat[8:0], last_dr};
        end
        chk("starve_pattern", 32'(pat), 32'b11_1101_1110);
        i_req = 1'b0; d_req = 1'b0;
        cyc();
        i_req = 1'b1; i_addr = 32'h0000_4008;
        cyc();
        chk("wrap_maddr", last_maddr, 32'd2);
        i_req = 1'b0;
        cyc();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        for (int n = 0; n < 4; n++) cyc();
        chk("rst_pre_grant", 32'(last_dr), 32'd1);
        rst_n = 1'b0;
        cyc();
        chk("rst_drop", 32'(last_drv), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_col", 32'(last_dr), 32'd1);
        i_req = 1'b0; d_req = 1'b0;
        cyc();
        for (int n = 0; n < 600; n++) begin
            if (!d_req || last_dr) begin
                d_req = ($urandom % 3) != 0;
                d_we = $urandom % 2;
                d_wstrb = 4'($urandom);
                d_wdata = $urandom;
                d_addr = ($urandom & 32'hFFFF_C000) | (($urandom % 64) << 2) | ($urandom % 4);
            end
            if (!i_req || last_ir || ($urandom % 8) == 0) begin
                i_req = ($urandom % 3) != 0;
                i_addr = ($urandom & 32'hFFFF_C000) | (($urandom % 64) << 2);
            end
            rst_n = ($urandom % 64) != 0;
            cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Two-requester arbiter that shares one single-ported synchronous SRAM between the RV32I instruction-fetch port and the data/load-store port. It sits between the core's fetch and data buses and the unified program/data RAM. Each cycle it grants at most one request, drives the RAM, and routes the one-cycle-latency response back to the requester that won. Data accesses have priority, with a bounded-starvation guard for fetch.

## Interface
- ADDR_W, 12, RAM word-address width (2^ADDR_W 32-bit words)
- STARVE_MAX, 4, max consecutive data grants while fetch waits; legal range 1..15
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_req  in  1  fetch request valid
- i_addr  in  32  fetch byte address
- i_ready  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch response valid
- i_rdata  out  32  fetch read data
- d_req  in  1  data request valid
- d_we  in  1  1 = write, 0 = read
- d_wstrb  in  4  byte-write strobes, used only when d_we=1
- d_addr  in  32  data byte address
- d_wdata  in  32  write data, already lane-aligned
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  data response valid (read data or write ack)
- d_rdata  out  32  data read data
- m_en  out  1  RAM access enable
- m_we  out  4  RAM byte write enables
- m_addr  out  ADDR_W  RAM word address
- m_wdata  out  32  RAM write data
- m_rdata  in  32  RAM read data, registered, valid the cycle after m_en

## Operation
- Request side is valid/ready: a requester holds addr, we, wstrb and wdata stable from req high until the cycle ready=1. The transfer occurs in that cycle.
- Grant logic is combinational from current inputs and state. i_ready, d_ready and m_* are functions of the same cycle's inputs. At most one of i_ready and d_ready is high.
- Grant rules when rst_n=1:
  - only d_req: grant d
  - only i_req: grant i
  - both: grant d unless starve_cnt == STARVE_MAX, then grant i
  - neither: no grant, m_en=0
- starve_cnt (4 bits) updates as follows:
  - increments when i_req=1 and d is granted
  - clears when i is granted or i_req=0
  - saturates at STARVE_MAX
- On a grant, m_en=1 and m_addr = addr[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo RAM size.
  - i grant: m_we=0.
  - d grant: m_we = d_we ? d_wstrb : 0, m_wdata = d_wdata.
  - d write with d_wstrb=0: still a granted access with no bytes written, and it is acked.
- With no grant, m_we=0, m_addr=0 and m_wdata=0.
- Response tracking registers: resp_v, resp_sel (0=i, 1=d), resp_wr. They load on every cycle's grant decision.
- Cycle after a grant, exactly one of i_rvalid/d_rvalid pulses for one cycle.
  - Read response: rdata = m_rdata.
  - Write response: d_rdata = 0.
  - Non-selected port's rdata is 0.
- Responses are in order, one per grant, with no buffering. Back-to-back grants give one response per cycle.

## Timing
- Throughput: 1 access/cycle. Latency: grant cycle N → rvalid in cycle N+1.
- Reset (rst_n=0 at a rising edge) clears resp_v, resp_sel, resp_wr and starve_cnt.
- While rst_n=0, i_ready, d_ready, m_en, m_we, i_rvalid and d_rvalid are all 0; rdata outputs and m_addr/m_wdata are 0.
- Reset mid-operation: a response due in the cycle after reset asserts is dropped, with no rvalid. The first grant is possible in the first cycle with rst_n=1.
- Simultaneous request and response on the same port in the same cycle is legal. The new grant's response follows in the next cycle.
- A requester that drops req before ready gets no access and no response. This is legal for fetch (redirect) and must leave the counter consistent per the rules above.

## Test plan
- Fetch read:
  - Stimulus: RAM word 3 = 0x00000013; i_req=1, i_addr=0x0C, d_req=0.
  - Required: i_ready=1, m_en=1, m_addr=3 same cycle; next cycle i_rvalid=1, i_rdata=0x00000013, d_rvalid=0.
- Data byte write then read:
  - Stimulus: d_we=1, d_addr=0x41, d_wstrb=0010, d_wdata=0x0000AB00 onto word 0x10 = 0x11223344; then a read of 0x40.
  - Required: write gives d_rvalid=1 and d_rdata=0 next cycle; read returns 0x1122AB44.
- Collision:
  - Stimulus: i_req=d_req=1 for one cycle, starve_cnt=0.
  - Required: d_ready=1, i_ready=0; next cycle d_rvalid only; i is granted the following cycle if still requesting.
- Starvation guard:
  - Stimulus: STARVE_MAX=4; i_req and d_req held high for 10 cycles.
  - Required: grant pattern d,d,d,d,i,d,d,d,d,i; responses alternate ports accordingly, one per cycle.
- Address wrap:
  - Stimulus: ADDR_W=12, i_addr=0x00004008.
  - Required: m_addr=2.
- Reset mid-operation:
  - Stimulus: d read granted in cycle N, rst_n=0 in cycle N+1.
  - Required: no d_rvalid in N+1, all outputs 0 during reset, starve_cnt=0 after release (first collision grants d).
